// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue_pkg
// Description : Shared widths and the entry record for the instruction fetch
//               queue. An entry is {pc, inst, excep}. The excep field is
//               {excep_en, ecode[5:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_queue_pkg;

    localparam int c_PC_W    = 32;
    localparam int c_INST_W  = 32;
    localparam int c_EXCEP_W = 7;
    localparam int c_DINST_W = 64;
    localparam int c_ENTRY_W = c_PC_W + c_INST_W + c_EXCEP_W;

    typedef struct packed {
        logic [c_PC_W-1:0]    pc;
        logic [c_INST_W-1:0]  inst;
        logic [c_EXCEP_W-1:0] excep;
    } fq_entry_t;

    function automatic fq_entry_t make_entry(
        input logic [c_PC_W-1:0]    pc,
        input logic [c_INST_W-1:0]  inst,
        input logic [c_EXCEP_W-1:0] excep
    );
        fq_entry_t e;
        e.pc    = pc;
        e.inst  = inst;
        e.excep = excep;
        return e;
    endfunction

endpackage : inst_fetch_queue_pkg
`default_nettype wire

// File: rtl/inst_fetch_queue_ram.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue_ram
// Description : DEPTH x entry register array, two write ports, two
//               asynchronous read ports. The contents are not reset; the
//               parent qualifies all reads with its own valid tracking.
// Ports       : clk                          - clock
//               i_we0/i_waddr0/i_wdata0      - write port 0
//               i_we1/i_waddr1/i_wdata1      - write port 1 (never the same
//                                              address as port 0)
//               i_raddr0/o_rdata0            - read port 0 (combinational)
//               i_raddr1/o_rdata1            - read port 1 (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue_ram
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we0,
    input  logic [PTR_W-1:0] i_waddr0,
    input  fq_entry_t        i_wdata0,
    input  logic             i_we1,
    input  logic [PTR_W-1:0] i_waddr1,
    input  fq_entry_t        i_wdata1,
    input  logic [PTR_W-1:0] i_raddr0,
    output fq_entry_t        o_rdata0,
    input  logic [PTR_W-1:0] i_raddr1,
    output fq_entry_t        o_rdata1
);

    fq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule : inst_fetch_queue_ram
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Circular instruction queue between the IF and ID stages.
//               It accepts 1 or 2 instructions per cycle and presents up to
//               2 entries (head, head+1) per cycle to decode.
//               Optional feature macro INST_FETCH_QUEUE_BYPASS_EN: when the
//               queue is empty, an accepted packet is presented in the same
//               cycle. Only entries that decode does not take are stored.
// Ports       : clk, rst (async, active-high)
//               flush_i                 - drop everything, including this
//                                         cycle's packet
//               pre_*                   - incoming fetch packet / allowin
//               next_allowin_i          - decode takes the presented entries
//               line{1,2}_*_o           - presented entries
//               count_o                 - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          pre_valid_i,
    input  logic                          pre_line2_valid_i,
    input  logic [c_PC_W-1:0]             pre_pc_i,
    input  logic [c_DINST_W-1:0]          pre_inst_i,
    input  logic [c_EXCEP_W-1:0]          pre_excep_i,
    output logic                          pre_allowin_o,
    input  logic                          next_allowin_i,
    output logic                          line1_valid_o,
    output logic                          line2_valid_o,
    output logic [c_PC_W-1:0]             line1_pc_o,
    output logic [c_PC_W-1:0]             line2_pc_o,
    output logic [c_INST_W-1:0]           line1_inst_o,
    output logic [c_INST_W-1:0]           line2_inst_o,
    output logic [c_EXCEP_W-1:0]          line1_excep_o,
    output logic [c_EXCEP_W-1:0]          line2_excep_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_accept;
    logic               w_bypass;
    logic               w_l1v;
    logic               w_l2v;
    logic [1:0]         w_n_in;
    logic [1:0]         w_pop;
    logic [1:0]         w_skip;
    logic [1:0]         w_n_wr;
    fq_entry_t          w_in0;
    fq_entry_t          w_in1;
    fq_entry_t          w_rd0;
    fq_entry_t          w_rd1;
    fq_entry_t          w_e1;
    fq_entry_t          w_e2;
    fq_entry_t          w_wdata0;

    // Allowin depends only on registered occupancy, so decode readiness never
    // reaches the fetch stage combinationally.
    assign pre_allowin_o = (c_CNT_W'(DEPTH) - r_count) >= c_CNT_W'(2);
    assign w_accept      = pre_valid_i & pre_allowin_o & ~flush_i;
    assign w_n_in        = w_accept ? (pre_line2_valid_i ? 2'd2 : 2'd1) : 2'd0;

    assign w_in0 = make_entry(pre_pc_i, pre_inst_i[31:0], pre_excep_i);
    assign w_in1 = make_entry(pre_pc_i + 32'd4, pre_inst_i[63:32], pre_excep_i);

`ifdef INST_FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_accept & (r_count == '0) & ~rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_l1v = w_bypass | ((r_count >= c_CNT_W'(1)) & ~flush_i);
    assign w_l2v = w_bypass ? pre_line2_valid_i
                            : ((r_count >= c_CNT_W'(2)) & ~flush_i);

    assign w_pop = next_allowin_i ? ({1'b0, w_l1v} + {1'b0, w_l2v}) : 2'd0;

    // On a bypass the popped entries come straight from the incoming packet,
    // so they are skipped when writing and do not move head.
    assign w_skip   = w_bypass ? w_pop : 2'd0;
    assign w_n_wr   = w_n_in - w_skip;
    assign w_wdata0 = (w_skip == 2'd0) ? w_in0 : w_in1;

    inst_fetch_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (c_PTR_W)
    ) u_ram (
        .clk      (clk),
        .i_we0    (w_n_wr != 2'd0),
        .i_waddr0 (r_tail),
        .i_wdata0 (w_wdata0),
        .i_we1    (w_n_wr == 2'd2),
        .i_waddr1 (r_tail + c_PTR_W'(1)),
        .i_wdata1 (w_in1),
        .i_raddr0 (r_head),
        .o_rdata0 (w_rd0),
        .i_raddr1 (r_head + c_PTR_W'(1)),
        .o_rdata1 (w_rd1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_pop - w_skip);
            r_tail  <= r_tail + c_PTR_W'(w_n_wr);
            r_count <= r_count + c_CNT_W'(w_n_in) - c_CNT_W'(w_pop);
        end
    end

    assign w_e1 = w_bypass ? w_in0 : w_rd0;
    assign w_e2 = w_bypass ? w_in1 : w_rd1;

    // Data outputs are zero whenever their line is not valid, which keeps
    // uninitialised array contents off the bus.
    assign line1_valid_o = w_l1v;
    assign line2_valid_o = w_l2v;
    assign line1_pc_o    = w_l1v ? w_e1.pc    : '0;
    assign line1_inst_o  = w_l1v ? w_e1.inst  : '0;
    assign line1_excep_o = w_l1v ? w_e1.excep : '0;
    assign line2_pc_o    = w_l2v ? w_e2.pc    : '0;
    assign line2_inst_o  = w_l2v ? w_e2.inst  : '0;
    assign line2_excep_o = w_l2v ? w_e2.excep : '0;
    assign count_o       = r_count;

endmodule : inst_fetch_queue
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Self-checking bench for inst_fetch_queue using a queue-based
//               reference model, directed scenarios and random traffic.
//               Honours INST_FETCH_QUEUE_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        pre_valid_i;
    logic        pre_line2_valid_i;
    logic [31:0] pre_pc_i;
    logic [63:0] pre_inst_i;
    logic [6:0]  pre_excep_i;
    logic        pre_allowin_o;
    logic        next_allowin_i;
    logic        line1_valid_o;
    logic        line2_valid_o;
    logic [31:0] line1_pc_o;
    logic [31:0] line2_pc_o;
    logic [31:0] line1_inst_o;
    logic [31:0] line2_inst_o;
    logic [6:0]  line1_excep_o;
    logic [6:0]  line2_excep_o;
    logic [3:0]  count_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [70:0] q [$];

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .pre_valid_i       (pre_valid_i),
        .pre_line2_valid_i (pre_line2_valid_i),
        .pre_pc_i          (pre_pc_i),
        .pre_inst_i        (pre_inst_i),
        .pre_excep_i       (pre_excep_i),
        .pre_allowin_o     (pre_allowin_o),
        .next_allowin_i    (next_allowin_i),
        .line1_valid_o     (line1_valid_o),
        .line2_valid_o     (line2_valid_o),
        .line1_pc_o        (line1_pc_o),
        .line2_pc_o        (line2_pc_o),
        .line1_inst_o      (line1_inst_o),
        .line2_inst_o      (line2_inst_o),
        .line1_excep_o     (line1_excep_o),
        .line2_excep_o     (line2_excep_o),
        .count_o           (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pre_valid_i       = 1'b0;
        pre_line2_valid_i = 1'b0;
        pre_pc_i          = '0;
        pre_inst_i        = '0;
        pre_excep_i       = '0;
        flush_i           = 1'b0;
        next_allowin_i    = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cnt"},   72'(count_o),       72'(0));
        chk({tag, "_l1v"},   72'(line1_valid_o), 72'(0));
        chk({tag, "_l2v"},   72'(line2_valid_o), 72'(0));
        chk({tag, "_allow"}, 72'(pre_allowin_o), 72'(1));
        chk({tag, "_data"},  72'({line1_pc_o, line1_inst_o, line1_excep_o}), 72'(0));
    endtask

    // One clock cycle: drive, check against the model at mid-cycle, update
    // the model, advance past the edge and return the inputs to idle.
    task automatic cycle(input logic pv, input logic l2, input logic [31:0] pc,
                         input logic [63:0] inst, input logic [6:0] exc,
                         input logic fl, input logic nx);
        logic [70:0] inc [$];
        logic [70:0] pres [$];
        logic [70:0] e1, e2;
        logic        allow, acc, byp;
        int          pop;
        pre_valid_i = pv; pre_line2_valid_i = l2; pre_pc_i = pc;
        pre_inst_i = inst; pre_excep_i = exc; flush_i = fl; next_allowin_i = nx;
        allow = (DEPTH - q.size()) >= 2;
        acc   = pv && allow && !fl;
        inc   = {};
        if (acc) begin
            inc.push_back({pc, inst[31:0], exc});
            if (l2) inc.push_back({pc + 32'd4, inst[63:32], exc});
        end
        byp = 1'b0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        byp = acc && (q.size() == 0);
`endif
        pres = {};
        if (!fl) begin
            if (byp) pres = inc;
            else for (int i = 0; i < 2 && i < q.size(); i++) pres.push_back(q[i]);
        end
        e1 = (pres.size() >= 1) ? pres[0] : '0;
        e2 = (pres.size() >= 2) ? pres[1] : '0;
        #4;
        chk("allowin", 72'(pre_allowin_o), 72'(allow));
        chk("count",   72'(count_o),       72'(q.size()));
        chk("l1v",     72'(line1_valid_o), 72'(pres.size() >= 1));
        chk("l2v",     72'(line2_valid_o), 72'(pres.size() >= 2));
        chk("line1",   72'({line1_pc_o, line1_inst_o, line1_excep_o}), 72'(e1));
        chk("line2",   72'({line2_pc_o, line2_inst_o, line2_excep_o}), 72'(e2));
        pop = nx ? pres.size() : 0;
        if (fl) begin
            q.delete();
        end else if (byp) begin
            for (int i = pop; i < inc.size(); i++) q.push_back(inc[i]);
        end else begin
            repeat (pop) void'(q.pop_front());
            foreach (inc[i]) q.push_back(inc[i]);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push2(input logic [31:0] pc, input logic nx);
        cycle(1'b1, 1'b1, pc, {$urandom, $urandom}, 7'($urandom), 1'b0, nx);
    endtask

    task automatic push1(input logic [31:0] pc, input logic nx);
        cycle(1'b1, 1'b0, pc, {32'h0, $urandom}, 7'($urandom), 1'b0, nx);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        chk_quiet("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill: three packets leave room for one more, the fourth fills it.
        push2(32'h1c000000, 1'b0);
        push2(32'h1c000008, 1'b0);
        push2(32'h1c000010, 1'b0);
        chk("fill6_cnt",   72'(count_o),       72'(6));
        chk("fill6_allow", 72'(pre_allowin_o), 72'(1));
        push2(32'h1c000018, 1'b0);
        chk("fill8_cnt",   72'(count_o),       72'(8));
        chk("fill8_allow", 72'(pre_allowin_o), 72'(0));

        // Drain two per cycle in order.
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc1", 72'(line1_pc_o), 72'(32'h1c000000 + 32'(i * 8)));
            chk("drain_pc2", 72'(line2_pc_o), 72'(32'h1c000004 + 32'(i * 8)));
            cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        end
        chk("drain_cnt", 72'(count_o), 72'(0));

        // Simultaneous push and pop at count 1.
        push1(32'h1c000100, 1'b0);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        chk("pp_pre_cnt", 72'(count_o), 72'(1));
`endif
        push1(32'h1c000200, 1'b1);
        chk("pp_cnt", 72'(count_o),    72'(1));
        chk("pp_pc",  72'(line1_pc_o), 72'(32'h1c000200));
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);

        // Flush at count 5 with a packet offered.
        push2(32'h1c000300, 1'b0);
        push2(32'h1c000308, 1'b0);
        push1(32'h1c000310, 1'b0);
        chk("fl_pre_cnt", 72'(count_o), 72'(5));
        cycle(1'b1, 1'b1, 32'h1c000400, 64'h1111_2222_3333_4444, 7'h05, 1'b1, 1'b1);
        chk_quiet("flush");

        // Walk pointers to 7 then push a pair across the wrap.
        for (int i = 0; i < 7; i++) push1(32'h1c000500 + 32'(i * 4), 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("wrap_pre_cnt", 72'(count_o), 72'(0));
        push2(32'h1c000600, 1'b0);
`ifndef INST_FETCH_QUEUE_BYPASS_EN
        chk("wrap_pc1", 72'(line1_pc_o), 72'(32'h1c000600));
        chk("wrap_pc2", 72'(line2_pc_o), 72'(32'h1c000604));
`endif
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);

        // Empty queue, accept with decode ready.
        push2(32'h1c000700, 1'b1);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        chk("byp_cnt", 72'(count_o),       72'(0));
        chk("byp_l1v", 72'(line1_valid_o), 72'(0));
`else
        chk("nobyp_cnt", 72'(count_o),    72'(2));
        chk("nobyp_pc",  72'(line1_pc_o), 72'(32'h1c000700));
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
`endif

        // Random traffic with one asynchronous reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                push2(32'h1c000800, 1'b0);
                rst = 1'b1;
                #2;
                chk_quiet("midrst");
                q.delete();
                rst = 1'b0;
                @(posedge clk);
                #1;
            end
            cycle(($urandom % 4) != 0, 1'($urandom), {$urandom, 2'b00}[31:0],
                  {$urandom, $urandom}, 7'($urandom), ($urandom % 32) == 0,
                  1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_inst_fetch_queue
`default_nettype wire
